// File: rtl/pico_stream_in.sv
// pico_stream_in: host-to-FPGA stream endpoint buffering host data beats and descriptors, with a FWFT user port and credit polling
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m_valid/m_data/m_rdy     user data stream (valid/ready, first-word-fall-through)
//   s_in_valid/id/data       host write bus; data tag {0,1,ID}, descriptor tag {1,1,ID}
//   s_poll_id                poll tag; registered answer on s_poll_seq/next_desc/next_desc_valid
//   s_next_desc_rd_id/rd_en  descriptor pop request (matched against the data tag)
//   err_overflow             sticky: a host write hit a full FIFO
module pico_stream_in #(
    parameter int ID              = 1,
    parameter int DESC_FIFO_DEPTH = 32,
    parameter int DATA_FIFO_DEPTH = 512,
    parameter int CREDIT_MARGIN   = 8
) (
    input  logic         clk,
    input  logic         rst,
    output logic         m_valid,
    output logic [127:0] m_data,
    input  logic         m_rdy,
    input  logic         s_in_valid,
    input  logic [8:0]   s_in_id,
    input  logic [127:0] s_in_data,
    input  logic [8:0]   s_poll_id,
    output logic [31:0]  s_poll_seq,
    output logic [127:0] s_poll_next_desc,
    output logic         s_poll_next_desc_valid,
    input  logic [8:0]   s_next_desc_rd_id,
    input  logic         s_next_desc_rd_en,
    output logic         err_overflow
);
    localparam int DAW = $clog2(DATA_FIFO_DEPTH);
    localparam int QAW = $clog2(DESC_FIFO_DEPTH);
    localparam logic [6:0]  ID7           = ID[6:0];
    localparam logic [8:0]  DATA_TAG      = {2'b01, ID7};
    localparam logic [8:0]  DESC_TAG      = {2'b11, ID7};
    localparam logic [31:0] DATA_SEQ_INIT = 16 * (DATA_FIFO_DEPTH - CREDIT_MARGIN);
    localparam logic [31:0] DESC_SEQ_INIT = 16 * DESC_FIFO_DEPTH;
    localparam logic [DAW:0] DATA_CAP     = DATA_FIFO_DEPTH[DAW:0];
    localparam logic [QAW:0] DESC_CAP     = DESC_FIFO_DEPTH[QAW:0];
    localparam logic [DAW:0] DINC         = {{DAW{1'b0}}, 1'b1};
    localparam logic [QAW:0] QINC         = {{QAW{1'b0}}, 1'b1};

    logic         in_valid_q;
    logic [8:0]   in_id_q;
    logic [127:0] in_data_q;

    always_ff @(posedge clk) begin
        in_valid_q <= rst ? 1'b0 : s_in_valid;
        in_id_q    <= s_in_id;
        in_data_q  <= s_in_data;
    end

    logic [127:0] data_mem [DATA_FIFO_DEPTH];
    logic [DAW:0] data_wp, data_rp, data_cnt;
    logic         data_wr, data_full, data_push, data_load, xfer;

    // occupancy includes the output register so the full FIFO holds exactly DATA_FIFO_DEPTH beats
    assign data_cnt  = (data_wp - data_rp) + {{DAW{1'b0}}, m_valid};
    assign data_wr   = in_valid_q && in_id_q == DATA_TAG;
    assign data_full = data_cnt == DATA_CAP;
    assign data_push = data_wr && !data_full;
    assign xfer      = m_valid && m_rdy;
    assign data_load = data_wp != data_rp && (!m_valid || m_rdy);

    always_ff @(posedge clk) begin
        if (data_push) data_mem[data_wp[DAW-1:0]] <= in_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_wp <= '0;
            data_rp <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (data_push) data_wp <= data_wp + DINC;
            if (data_load) data_rp <= data_rp + DINC;
            if (data_load) m_data <= data_mem[data_rp[DAW-1:0]];
            m_valid <= data_load || (m_valid && !m_rdy);
        end
    end

    logic [127:0] desc_mem [DESC_FIFO_DEPTH];
    logic [QAW:0] desc_wp, desc_rp;
    logic [127:0] desc_head;
    logic         desc_wr, desc_full, desc_empty, desc_push, desc_pop, pop_q;

    assign desc_wr    = in_valid_q && in_id_q == DESC_TAG;
    assign desc_empty = desc_wp == desc_rp;
    assign desc_full  = (desc_wp - desc_rp) == DESC_CAP;
    assign desc_push  = desc_wr && !desc_full;
    assign desc_pop   = pop_q && !desc_empty;
    assign desc_head  = desc_mem[desc_rp[QAW-1:0]];

    always_ff @(posedge clk) begin
        if (desc_push) desc_mem[desc_wp[QAW-1:0]] <= in_data_q;
    end

    // pop requests carry the data tag; they are registered and act one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q   <= 1'b0;
            desc_wp <= '0;
            desc_rp <= '0;
        end else begin
            pop_q <= s_next_desc_rd_en && s_next_desc_rd_id == DATA_TAG;
            if (desc_push) desc_wp <= desc_wp + QINC;
            if (desc_pop) desc_rp <= desc_rp + QINC;
        end
    end

    logic [31:0] data_seq, desc_seq;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_seq     <= DATA_SEQ_INIT;
            desc_seq     <= DESC_SEQ_INIT;
            err_overflow <= 1'b0;
        end else begin
            if (xfer) data_seq <= data_seq + 32'd16;
            if (desc_pop) desc_seq <= desc_seq + 32'd16;
            if ((data_wr && data_full) || (desc_wr && desc_full)) err_overflow <= 1'b1;
        end
    end

    // poll answers sample state before this edge's updates
    always_ff @(posedge clk) begin
        if (rst) begin
            s_poll_seq             <= '0;
            s_poll_next_desc       <= '0;
            s_poll_next_desc_valid <= 1'b0;
        end else begin
            s_poll_seq             <= s_poll_id == DESC_TAG ? desc_seq :
                                      s_poll_id == DATA_TAG ? data_seq : '0;
            s_poll_next_desc       <= s_poll_id == DATA_TAG && !desc_empty ? desc_head : '0;
            s_poll_next_desc_valid <= s_poll_id == DATA_TAG && !desc_empty;
        end
    end
endmodule

// File: tb/tb_pico_stream_in.sv
// tb_pico_stream_in: randomized self-checking bench for pico_stream_in against a queue-based reference model
module tb_pico_stream_in;
    localparam logic [8:0] DTAG   = 9'h081;
    localparam logic [8:0] QTAG   = 9'h181;
    localparam logic [8:0] XTAG   = 9'h082;
    localparam int         DEPTH  = 512;
    localparam int         QDEPTH = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m_valid;
    logic [127:0] m_data;
    logic         m_rdy = 1'b0;
    logic         s_in_valid = 1'b0;
    logic [8:0]   s_in_id = '0;
    logic [127:0] s_in_data = '0;
    logic [8:0]   s_poll_id = '0;
    logic [31:0]  s_poll_seq;
    logic [127:0] s_poll_next_desc;
    logic         s_poll_next_desc_valid;
    logic [8:0]   s_next_desc_rd_id = '0;
    logic         s_next_desc_rd_en = 1'b0;
    logic         err_overflow;

    pico_stream_in dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_data(m_data), .m_rdy(m_rdy),
        .s_in_valid(s_in_valid), .s_in_id(s_in_id), .s_in_data(s_in_data),
        .s_poll_id(s_poll_id), .s_poll_seq(s_poll_seq),
        .s_poll_next_desc(s_poll_next_desc), .s_poll_next_desc_valid(s_poll_next_desc_valid),
        .s_next_desc_rd_id(s_next_desc_rd_id), .s_next_desc_rd_en(s_next_desc_rd_en),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           mode = 0;
    logic [127:0] exp_q[$];
    logic [127:0] desc_q[$];
    logic [31:0]  ref_data_seq = 32'h1F80;
    logic [31:0]  ref_desc_seq = 32'h200;
    logic         ref_err = 1'b0;
    logic         stall_prev = 1'b0;
    logic [127:0] data_prev = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // m_rdy policy: 0 = held low, 1 = held high, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        m_rdy = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 1;
    end

    // output monitor: transfers and stall stability are judged at the falling edge
    always @(negedge clk) begin
        if (rst) stall_prev = 1'b0;
        else begin
            if (stall_prev) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, data_prev);
            end
            if (m_valid && m_rdy) begin
                check("beat_avail", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("beat_data", m_data, exp_q.pop_front());
                ref_data_seq += 32'd16;
            end
            stall_prev = m_valid && !m_rdy;
            data_prev  = m_data;
        end
    end

    task automatic host_wr(input logic [8:0] id, input logic [127:0] d);
        s_in_valid = 1'b1;
        s_in_id    = id;
        s_in_data  = d;
        tick();
        s_in_valid = 1'b0;
        if (id == DTAG) begin
            if (exp_q.size() >= DEPTH) ref_err = 1'b1;
            else exp_q.push_back(d);
        end else if (id == QTAG) begin
            if (desc_q.size() >= QDEPTH) ref_err = 1'b1;
            else desc_q.push_back(d);
        end
    endtask

    task automatic pop(input logic [8:0] id);
        s_next_desc_rd_en = 1'b1;
        s_next_desc_rd_id = id;
        tick();
        s_next_desc_rd_en = 1'b0;
        if (id == DTAG && desc_q.size() != 0) begin
            void'(desc_q.pop_front());
            ref_desc_seq += 32'd16;
        end
    endtask

    task automatic poll(input logic [8:0] id);
        repeat (4) tick();
        s_poll_id = id;
        tick();
        s_poll_id = '0;
        check($sformatf("poll_seq_%h", id), s_poll_seq,
              id == QTAG ? ref_desc_seq : id == DTAG ? ref_data_seq : 32'd0);
        check($sformatf("poll_desc_%h", id), s_poll_next_desc,
              id == DTAG && desc_q.size() != 0 ? desc_q[0] : 128'd0);
        check($sformatf("poll_dvalid_%h", id), s_poll_next_desc_valid,
              id == DTAG && desc_q.size() != 0);
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (exp_q.size() != 0 && used < budget) begin
            tick();
            used++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        desc_q.delete();
        ref_data_seq = 32'h1F80;
        ref_desc_seq = 32'h200;
        ref_err      = 1'b0;
        tick();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 128'd0);
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int used;
        int lat;
        tick();
        do_reset();
        check("rst_err", err_overflow, 1'b0);
        check("rst_poll_seq", s_poll_seq, 32'd0);
        check("rst_poll_dvalid", s_poll_next_desc_valid, 1'b0);
        poll(DTAG);
        poll(QTAG);
        poll(XTAG);

        for (int i = 0; i < 3; i++) host_wr(QTAG, {{30{4'hA}}, 8'hA0 + 8'(i)});
        poll(DTAG);
        pop(QTAG);
        pop(DTAG);
        poll(DTAG);
        poll(QTAG);
        repeat (3) pop(DTAG);
        poll(QTAG);
        poll(DTAG);

        mode = 0;
        host_wr(DTAG, 128'h1234_5678);
        lat = 0;
        while (!m_valid && lat < 3) begin
            tick();
            lat++;
        end
        check("latency_valid", m_valid, 1'b1);
        mode = 1;
        drain(20, used);

        for (int i = 0; i < 100; i++) begin
            host_wr(DTAG, 128'(i + 1000));
            if (i % 25 == 0) host_wr(XTAG, rnd128());
        end
        drain(8, used);
        check("throughput", used <= 4, 1'b1);
        poll(DTAG);

        mode = 0;
        repeat (2) tick();
        for (int i = 0; i < 504; i++) host_wr(DTAG, rnd128());
        poll(DTAG);
        check("err_504", err_overflow, ref_err);
        mode = 2;
        drain(5000, used);
        mode = 1;
        poll(DTAG);
        check("err_after_504", err_overflow, ref_err);

        mode = 0;
        repeat (2) tick();
        for (int i = 0; i < DEPTH; i++) host_wr(DTAG, rnd128());
        repeat (4) tick();
        check("err_full", err_overflow, ref_err);
        host_wr(DTAG, rnd128());
        repeat (4) tick();
        check("err_overflow_set", err_overflow, ref_err);
        host_wr(XTAG, rnd128());
        repeat (10) tick();
        check("err_sticky", err_overflow, ref_err);
        poll(DTAG);
        do_reset();
        check("err_cleared", err_overflow, ref_err);
        poll(DTAG);
        poll(QTAG);

        mode = 0;
        for (int i = 0; i < 10; i++) begin
            host_wr(DTAG, rnd128());
            host_wr(XTAG, rnd128());
        end
        repeat (4) tick();
        check("pre_rst_valid", m_valid, 1'b1);
        do_reset();
        mode = 1;
        repeat (10) tick();
        check("no_stale_valid", m_valid, 1'b0);
        for (int i = 0; i < 5; i++) host_wr(DTAG, rnd128());
        drain(20, used);
        poll(DTAG);
        check("err_final", err_overflow, ref_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
